// File: rtl/mem_sram_ctrl_pkg.sv
// Shared definitions for the memory-stage SRAM controller.
// Holds the datapath widths, the data-memory base address, the FSM state
// encodings and a helper that forms an SRAM half-word address.
package mem_sram_ctrl_pkg;

  localparam int unsigned WORD_LEN      = 32;
  localparam int unsigned DATA_MEM_BASE = 1024;
  localparam int unsigned SRAM_ADDR_LEN = 18;
  localparam int unsigned SRAM_DATA_LEN = 16;
  // One SRAM address bit selects the half-word, the rest index the word.
  localparam int unsigned WORD_IDX_LEN  = SRAM_ADDR_LEN - 1;

  typedef logic [1:0] state_t;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LO   = 2'd1;
  localparam logic [1:0] S_HI   = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  function automatic logic [SRAM_ADDR_LEN-1:0] sram_half_addr(
    input logic [WORD_IDX_LEN-1:0] word,
    input logic                    half
  );
    return {word, half};
  endfunction

endpackage

// File: rtl/mem_addr_xlate.sv
// Byte-address to SRAM word-index translation for the data memory.
// word = (addr - DATA_MEM_BASE) >> 2, truncated to WORD_IDX_LEN bits.
// Optional macro MEM_ADDR_CHECK_EN adds a 'bad' output flagging addresses
// below the base, not word-aligned, or beyond the SRAM word range.
// Ports:
//   addr in  WORD_LEN      byte address
//   word out WORD_IDX_LEN  SRAM word index
//   bad  out 1             (MEM_ADDR_CHECK_EN only) address rejected
module mem_addr_xlate
  import mem_sram_ctrl_pkg::*;
(
  input  logic [WORD_LEN-1:0]     addr,
  output logic [WORD_IDX_LEN-1:0] word
`ifdef MEM_ADDR_CHECK_EN
  ,
  output logic                    bad
`endif
);

  logic [WORD_LEN-1:0] offset;

  assign offset = addr - WORD_LEN'(DATA_MEM_BASE);
  assign word   = offset[WORD_IDX_LEN+1:2];

`ifdef MEM_ADDR_CHECK_EN
  assign bad = (addr < WORD_LEN'(DATA_MEM_BASE))
             || (offset[1:0] != 2'b00)
             || (offset[WORD_LEN-1:WORD_IDX_LEN+2] != '0);
`else
  // Unchecked build: byte-lane and out-of-range bits are simply dropped.
  logic unused_offset;
  assign unused_offset = ^{offset[WORD_LEN-1:WORD_IDX_LEN+2], offset[1:0]};
`endif

endmodule

// File: rtl/mem_sram_ctrl.sv
// Memory-stage controller: sequences 32-bit loads/stores onto a 16-bit
// asynchronous SRAM as two half-word accesses (low half, then high half),
// each held WAIT_CYCLES clocks. 'ready' low freezes the pipeline.
// Optional macro MEM_ADDR_CHECK_EN enables address checking and the
// addr_err port; without it every address is translated unchecked.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   rd_en, wr_en      load / store request (both set = store)
//   addr, st_val      byte address and store data
//   rd_data           load result, updated when a load completes
//   ready             0 = stall the pipeline
//   sram_addr/wdata   registered SRAM address and write data
//   sram_rdata        SRAM read data
//   sram_we_n/oe_n    registered active-low write strobe / output enable
//   addr_err          (MEM_ADDR_CHECK_EN only) request rejected this cycle
module mem_sram_ctrl
  import mem_sram_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 2
)
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rd_en,
  input  logic                     wr_en,
  input  logic [WORD_LEN-1:0]      addr,
  input  logic [WORD_LEN-1:0]      st_val,
  output logic [WORD_LEN-1:0]      rd_data,
  output logic                     ready,
  output logic [SRAM_ADDR_LEN-1:0] sram_addr,
  output logic [SRAM_DATA_LEN-1:0] sram_wdata,
  input  logic [SRAM_DATA_LEN-1:0] sram_rdata,
  output logic                     sram_we_n,
  output logic                     sram_oe_n
`ifdef MEM_ADDR_CHECK_EN
  ,
  output logic                     addr_err
`endif
);

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

  state_t                   state;
  logic [3:0]               wait_cnt;
  logic                     op_wr;
  logic [WORD_IDX_LEN-1:0]  word_idx;
  logic [WORD_IDX_LEN-1:0]  word_q;
  logic [WORD_LEN-1:0]      st_q;
  logic [SRAM_DATA_LEN-1:0] rd_lo;
  logic                     req;
  logic                     in_idle;
  logic                     addr_bad;
  logic                     start;

  assign req     = rd_en | wr_en;
  assign in_idle = (state == S_IDLE);

`ifdef MEM_ADDR_CHECK_EN
  mem_addr_xlate u_xlate (
    .addr (addr),
    .word (word_idx),
    .bad  (addr_bad)
  );
  assign addr_err = in_idle & req & addr_bad;
`else
  mem_addr_xlate u_xlate (
    .addr (addr),
    .word (word_idx)
  );
  assign addr_bad = 1'b0;
`endif

  assign start = in_idle & req & ~addr_bad;
  // Idle without an accepted request (none, or rejected) or DONE.
  assign ready = (in_idle & ~start) | (state == S_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      wait_cnt   <= '0;
      op_wr      <= 1'b0;
      word_q     <= '0;
      st_q       <= '0;
      rd_lo      <= '0;
      rd_data    <= '0;
      sram_addr  <= '0;
      sram_wdata <= '0;
      sram_we_n  <= 1'b1;
      sram_oe_n  <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            op_wr     <= wr_en;
            word_q    <= word_idx;
            st_q      <= st_val;
            wait_cnt  <= WAIT_LOAD;
            sram_addr <= sram_half_addr(word_idx, 1'b0);
            if (wr_en) sram_wdata <= st_val[SRAM_DATA_LEN-1:0];
            sram_we_n <= ~wr_en;
            sram_oe_n <= wr_en;
            state     <= S_LO;
          end
        end
        S_LO: begin
          if (wait_cnt == '0) begin
            // Low half is staged so rd_data only moves when the load completes.
            if (!op_wr) rd_lo <= sram_rdata;
            if (op_wr) sram_wdata <= st_q[WORD_LEN-1:SRAM_DATA_LEN];
            sram_addr <= sram_half_addr(word_q, 1'b1);
            wait_cnt  <= WAIT_LOAD;
            state     <= S_HI;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        S_HI: begin
          if (wait_cnt == '0) begin
            if (!op_wr) rd_data <= {sram_rdata, rd_lo};
            sram_we_n <= 1'b1;
            sram_oe_n <= 1'b1;
            state     <= S_DONE;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_sram_ctrl.sv
// Self-checking bench for mem_sram_ctrl (WAIT_CYCLES = 2) with a behavioural
// SRAM and a word-level reference memory. Build with MEM_ADDR_CHECK_EN to
// exercise the address-check configuration.
module tb_mem_sram_ctrl;

  localparam int unsigned W = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_en, wr_en;
  logic [31:0] addr, st_val, rd_data;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_wdata, sram_rdata;
  logic        sram_we_n, sram_oe_n;
`ifdef MEM_ADDR_CHECK_EN
  logic        addr_err;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_sram_ctrl #(.WAIT_CYCLES(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .rd_en      (rd_en),
    .wr_en      (wr_en),
    .addr       (addr),
    .st_val     (st_val),
    .rd_data    (rd_data),
    .ready      (ready),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata),
    .sram_we_n  (sram_we_n),
    .sram_oe_n  (sram_oe_n)
`ifdef MEM_ADDR_CHECK_EN
    ,
    .addr_err   (addr_err)
`endif
  );

  // Behavioural asynchronous SRAM.
  logic [15:0] sram_mem [0:262143];
  always @(posedge clk) if (!sram_we_n) sram_mem[sram_addr] <= sram_wdata;
  assign sram_rdata = sram_oe_n ? 16'h0000 : sram_mem[sram_addr];

  // Word-level reference model.
  logic [31:0] ref_mem [int unsigned];
  logic [31:0] exp_rd;
  logic [17:0] exp_last_addr;

  function automatic int unsigned word_of(input logic [31:0] a);
    return ((a - 32'd1024) >> 2) & 32'h1FFFF;
  endfunction

  function automatic logic [31:0] ref_read(input int unsigned w);
    return ref_mem.exists(w) ? ref_mem[w] : 32'h0;
  endfunction

  function automatic logic [17:0] exp_addr(input int unsigned w, input int k);
    return 18'(2 * w + ((k >= int'(W)) ? 1 : 0));
  endfunction

  task automatic model_txn(input logic wr, input logic rd, input logic [31:0] a,
                           input logic [31:0] v);
    int unsigned w = word_of(a);
    if (wr) ref_mem[w] = v;
    else if (rd) exp_rd = ref_read(w);
    exp_last_addr = 18'(2 * w + 1);
  endtask

  // Observations of one request.
  int          stall;
  logic        timeout;
  int          t_start;
  logic [17:0] ob_addr [64];
  logic        ob_we   [64];
  logic        ob_oe   [64];
  logic [15:0] ob_wd   [64];
  logic [31:0] ob_rd;
  logic        ob_err;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents a request at the current cycle, holds it while stalled and
  // records the SRAM pins each stalled cycle; returns one cycle after ready.
  task automatic do_req(input logic wr, input logic rd, input logic [31:0] a,
                        input logic [31:0] v);
    wr_en = wr; rd_en = rd; addr = a; st_val = v;
    stall = 0; timeout = 1'b0; ob_err = 1'b0; t_start = cyc;
    #1;
`ifdef MEM_ADDR_CHECK_EN
    ob_err = addr_err;
`endif
    while (!ready && !timeout) begin
      stall++;
      step();
      ob_addr[stall-1] = sram_addr;
      ob_we[stall-1]   = sram_we_n;
      ob_oe[stall-1]   = sram_oe_n;
      ob_wd[stall-1]   = sram_wdata;
      #1;
      if (stall >= 40) timeout = 1'b1;
    end
    ob_rd = rd_data;
    step();
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; addr = '0; st_val = '0;
    step(); step();
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", ready); end
    checks++; if (sram_we_n !== 1'b1) begin errors++; $display("FAIL reset_we_n got %b want 1", sram_we_n); end
    checks++; if (sram_oe_n !== 1'b1) begin errors++; $display("FAIL reset_oe_n got %b want 1", sram_oe_n); end
    checks++; if (sram_addr !== 18'h0) begin errors++; $display("FAIL reset_addr got %h want 0", sram_addr); end
    checks++; if (sram_wdata !== 16'h0) begin errors++; $display("FAIL reset_wdata got %h want 0", sram_wdata); end
    checks++; if (rd_data !== 32'h0) begin errors++; $display("FAIL reset_rd_data got %h want 0", rd_data); end
`ifdef MEM_ADDR_CHECK_EN
    checks++; if (addr_err !== 1'b0) begin errors++; $display("FAIL reset_addr_err got %b want 0", addr_err); end
`endif
    rst = 1'b0;
    exp_rd = 32'h0; exp_last_addr = 18'h0;
    step();
  endtask

  task automatic test_store();
    logic [31:0] v = 32'hDEADBEEF;
    do_req(1'b1, 1'b0, 32'd1024, v);
    model_txn(1'b1, 1'b0, 32'd1024, v);
    checks++; if (timeout || stall != int'(2*W+1)) begin errors++; $display("FAIL store_stall got %0d want %0d", stall, 2*W+1); end
    for (int k = 0; k < int'(2*W); k++) begin
      checks++; if (ob_addr[k] !== exp_addr(0, k)) begin errors++; $display("FAIL store_addr[%0d] got %h want %h", k, ob_addr[k], exp_addr(0, k)); end
      checks++; if (ob_we[k] !== 1'b0 || ob_oe[k] !== 1'b1) begin errors++; $display("FAIL store_strobes[%0d] got we_n=%b oe_n=%b want 0/1", k, ob_we[k], ob_oe[k]); end
      checks++; if (ob_wd[k] !== ((k < int'(W)) ? v[15:0] : v[31:16])) begin errors++; $display("FAIL store_wdata[%0d] got %h want %h", k, ob_wd[k], (k < int'(W)) ? v[15:0] : v[31:16]); end
    end
    checks++; if (ob_we[2*W] !== 1'b1) begin errors++; $display("FAIL store_done_we_n got %b want 1", ob_we[2*W]); end
  endtask

  task automatic test_load();
    do_req(1'b0, 1'b1, 32'd1024, 32'h0);
    model_txn(1'b0, 1'b1, 32'd1024, 32'h0);
    checks++; if (timeout || stall != int'(2*W+1)) begin errors++; $display("FAIL load_stall got %0d want %0d", stall, 2*W+1); end
    for (int k = 0; k < int'(2*W); k++) begin
      checks++; if (ob_oe[k] !== 1'b0 || ob_we[k] !== 1'b1) begin errors++; $display("FAIL load_strobes[%0d] got oe_n=%b we_n=%b want 0/1", k, ob_oe[k], ob_we[k]); end
      checks++; if (ob_addr[k] !== exp_addr(0, k)) begin errors++; $display("FAIL load_addr[%0d] got %h want %h", k, ob_addr[k], exp_addr(0, k)); end
    end
    checks++; if (ob_rd !== 32'hDEADBEEF || ob_rd !== exp_rd) begin errors++; $display("FAIL load_data got %h want %h", ob_rd, exp_rd); end
  endtask

  task automatic test_back_to_back();
    int t0;
    logic [31:0] v = $urandom;
    do_req(1'b1, 1'b0, 32'd1028, v);
    model_txn(1'b1, 1'b0, 32'd1028, v);
    t0 = t_start;
    do_req(1'b0, 1'b1, 32'd1028, 32'h0);
    model_txn(1'b0, 1'b1, 32'd1028, 32'h0);
    checks++; if (t_start - t0 != int'(2*W+2)) begin errors++; $display("FAIL b2b_spacing got %0d want %0d", t_start - t0, 2*W+2); end
    checks++; if (ob_addr[0] !== 18'd2 || ob_addr[W] !== 18'd3) begin errors++; $display("FAIL b2b_addr got %h,%h want 2,3", ob_addr[0], ob_addr[W]); end
    checks++; if (ob_rd !== v) begin errors++; $display("FAIL b2b_data got %h want %h", ob_rd, v); end
  endtask

  task automatic test_reset_mid_write();
    logic [31:0] v0 = 32'h1234_5678;
    logic [31:0] v1 = 32'hCAFE_F00D;
    do_req(1'b1, 1'b0, 32'd1064, v0);
    model_txn(1'b1, 1'b0, 32'd1064, v0);
    wr_en = 1'b1; addr = 32'd1064; st_val = v1;
    step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0; wr_en = 1'b0;
    #1;
    ref_mem[10] = {v0[31:16], v1[15:0]};
    exp_rd = 32'h0; exp_last_addr = 18'h0;
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready got %b want 1", ready); end
    checks++; if (sram_we_n !== 1'b1 || sram_oe_n !== 1'b1) begin errors++; $display("FAIL rstmid_strobes got we_n=%b oe_n=%b want 1/1", sram_we_n, sram_oe_n); end
    checks++; if (rd_data !== exp_rd) begin errors++; $display("FAIL rstmid_rd_data got %h want %h", rd_data, exp_rd); end
    checks++; if (sram_mem[21] !== v0[31:16]) begin errors++; $display("FAIL rstmid_hi_untouched got %h want %h", sram_mem[21], v0[31:16]); end
    step();
    do_req(1'b0, 1'b1, 32'd1064, 32'h0);
    model_txn(1'b0, 1'b1, 32'd1064, 32'h0);
    checks++; if (ob_rd !== exp_rd) begin errors++; $display("FAIL rstmid_readback got %h want %h", ob_rd, exp_rd); end
  endtask

  task automatic test_idle();
    for (int i = 0; i < 20; i++) begin
      step();
      checks++;
      if (ready !== 1'b1 || sram_we_n !== 1'b1 || sram_oe_n !== 1'b1 || sram_addr !== exp_last_addr) begin
        errors++;
        $display("FAIL idle[%0d] got ready=%b we_n=%b oe_n=%b addr=%h want 1 1 1 %h",
                 i, ready, sram_we_n, sram_oe_n, sram_addr, exp_last_addr);
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      int unsigned op = $urandom_range(0, 2);
      int unsigned w  = $urandom_range(0, 31);
      logic [31:0] a  = 32'd1024 + 32'(4 * w);
      logic [31:0] v  = $urandom;
      logic wr = (op != 1);
      logic rd = (op != 0);
      logic [31:0] rd_before = exp_rd;
      do_req(wr, rd, a, v);
      model_txn(wr, rd, a, v);
      checks++; if (timeout || stall != int'(2*W+1)) begin errors++; $display("FAIL rand%0d_stall got %0d want %0d", n, stall, 2*W+1); end
      checks++;
      if (ob_addr[0] !== exp_addr(w, 0) || ob_addr[W] !== exp_addr(w, int'(W)) ||
          ob_we[0] !== !wr || ob_oe[0] !== wr) begin
        errors++;
        $display("FAIL rand%0d_pins got addr=%h,%h we_n=%b oe_n=%b want %h,%h %b %b",
                 n, ob_addr[0], ob_addr[W], ob_we[0], ob_oe[0], exp_addr(w, 0), exp_addr(w, int'(W)), !wr, wr);
      end
      checks++;
      if (ob_rd !== exp_rd || (wr && ob_rd !== rd_before)) begin
        errors++;
        $display("FAIL rand%0d_rd_data got %h want %h", n, ob_rd, exp_rd);
      end
      repeat ($urandom_range(0, 2)) step();
    end
  endtask

`ifndef MEM_ADDR_CHECK_EN
  task automatic test_unchecked_xlate();
    logic [31:0] v = $urandom;
    logic [31:0] a = 32'd1024 + 32'(4 * (131072 + 7)) + 32'd3;
    do_req(1'b1, 1'b0, a, v);
    model_txn(1'b1, 1'b0, a, v);
    checks++; if (ob_addr[0] !== 18'd14 || ob_addr[W] !== 18'd15) begin errors++; $display("FAIL xlate_trunc got %h,%h want e,f", ob_addr[0], ob_addr[W]); end
    do_req(1'b0, 1'b1, 32'd1052, 32'h0);
    model_txn(1'b0, 1'b1, 32'd1052, 32'h0);
    checks++; if (ob_rd !== v) begin errors++; $display("FAIL xlate_readback got %h want %h", ob_rd, v); end
  endtask
`else
  task automatic test_addr_check();
    logic [31:0] bad_addrs [3];
    logic [31:0] v = 32'h0BAD_F00D;
    bad_addrs[0] = 32'd1026;
    bad_addrs[1] = 32'd1020;
    bad_addrs[2] = 32'd1024 + 32'(4 * 131072);
    for (int i = 0; i < 3; i++) begin
      do_req(1'b1, 1'b0, bad_addrs[i], $urandom);
      checks++; if (stall != 0 || ob_err !== 1'b1) begin errors++; $display("FAIL chk%0d_reject got stall=%0d err=%b want 0 1", i, stall, ob_err); end
      checks++; if (sram_we_n !== 1'b1 || addr_err !== 1'b0) begin errors++; $display("FAIL chk%0d_no_pulse got we_n=%b err=%b want 1 0", i, sram_we_n, addr_err); end
    end
    do_req(1'b1, 1'b0, 32'd1024, v);
    model_txn(1'b1, 1'b0, 32'd1024, v);
    checks++; if (ob_err !== 1'b0 || stall != int'(2*W+1)) begin errors++; $display("FAIL chk_valid got err=%b stall=%0d want 0 %0d", ob_err, stall, 2*W+1); end
    checks++; if (ob_addr[0] !== 18'd0 || ob_wd[0] !== 16'hF00D || ob_addr[W] !== 18'd1 || ob_wd[W] !== 16'h0BAD || ob_we[0] !== 1'b0) begin
      errors++; $display("FAIL chk_valid_pins got %h/%h %h/%h we_n=%b", ob_addr[0], ob_wd[0], ob_addr[W], ob_wd[W], ob_we[0]);
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < 262144; i++) sram_mem[i] = 16'h0;
    test_reset();
    test_store();
    test_load();
    test_back_to_back();
    test_reset_mid_write();
    test_idle();
    test_random();
`ifndef MEM_ADDR_CHECK_EN
    test_unchecked_xlate();
`else
    test_addr_check();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1);
  end

endmodule
